// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command codes, one-hot FSM states, burst/timing constants and address widths
package sdram_pkg;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MSET = 4'b0000;
  localparam int BL      = 4;
  localparam int T_RCD   = 4;
  localparam int T_RP    = 4;
  localparam int COL_W   = 9;
  localparam int ROW_W   = 13;
  localparam int BURST_W = 12;
  localparam logic [ROW_W-1:0] A10_ALL = 13'h0400;
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_REQ  = 5'b00010,
    S_ACT  = 5'b00100,
    S_RD   = 5'b01000,
    S_PRE  = 5'b10000
  } state_t;
endpackage

// File: rtl/sdram_rd_capture.sv
// sdram_rd_capture: valid pipeline matching CAS latency and dq low-byte capture (extra dq stage with SDRAM_RD_DQ_REG_EN)
module sdram_rd_capture #(
  parameter int CAS_LAT = 3
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       rd_slot,
  input  logic [7:0] dq,
  output logic       rfifo_wr_en,
  output logic [7:0] rfifo_wr_data
);
`ifdef SDRAM_RD_DQ_REG_EN
  localparam int DEPTH = CAS_LAT + 1;
  logic [7:0] dq_q;
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) dq_q <= '0;
    else dq_q <= dq;
`else
  localparam int DEPTH = CAS_LAT;
  logic [7:0] dq_q;
  assign dq_q = dq;
`endif
  logic [DEPTH-1:0] vld;
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) vld <= '0;
    else vld <= {vld[DEPTH-2:0], rd_slot};
  assign rfifo_wr_en   = vld[DEPTH-1];
  assign rfifo_wr_data = rfifo_wr_en ? dq_q : 8'h00;
endmodule

// File: rtl/sdram_read.sv
// sdram_read: ACTIVE/READ/PRECHARGE engine streaming BL=4 bursts into the read FIFO
// SDRAM_RD_DQ_REG_EN adds an input register on dq (one extra cycle of FIFO latency)
module sdram_read
  import sdram_pkg::*;
#(
  parameter int CAS_LAT   = 3,
  parameter int RD_BURSTS = 256,
  parameter int COL_LAST  = 511
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        rd_en,
  output logic        rd_req,
  output logic        flag_rd_end,
  input  logic        ref_req,
  input  logic        rd_trig,
  output logic [3:0]  rd_cmd,
  output logic [12:0] rd_addr,
  output logic [1:0]  bank_addr,
  input  logic [15:0] rd_data,
  output logic        rfifo_wr_en,
  output logic [7:0]  rfifo_wr_data
);
  state_t state;
  logic [1:0] cnt;
  logic flag_rd;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [BURST_W-1:0] burst;
  logic last_burst, row_end, stop, unused_dq_hi;
  assign last_burst   = burst == BURST_W'(RD_BURSTS - 1);
  assign row_end      = col == COL_W'(COL_LAST - 3);
  assign stop         = last_burst || ref_req || row_end;
  assign rd_req       = state == S_REQ;
  assign flag_rd_end  = state == S_PRE && cnt == 2'(T_RP - 1) && (ref_req || !flag_rd);
  assign bank_addr    = 2'b00;
  assign unused_dq_hi = ^rd_data[15:8];
  always_comb
    rd_addr = state == S_ACT ? row : state == S_RD ? ROW_W'(col) : state == S_PRE ? A10_ALL : '0;
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      flag_rd <= 1'b0;
      col     <= '0;
      row     <= '0;
      burst   <= '0;
      rd_cmd  <= CMD_NOP;
    end else begin
      rd_cmd <= CMD_NOP;
      cnt    <= state inside {S_ACT, S_RD, S_PRE} ? cnt + 2'd1 : 2'd0;
      case (state)
        S_IDLE: if (rd_trig) begin
          state   <= S_REQ;
          flag_rd <= 1'b1;
          col     <= '0;
          row     <= '0;
          burst   <= '0;
        end
        S_REQ: if (rd_en) begin
          state  <= S_ACT;
          rd_cmd <= CMD_ACT;
        end
        S_ACT: if (cnt == 2'(T_RCD - 1)) begin
          state  <= S_RD;
          rd_cmd <= CMD_RD;
        end
        S_RD: begin
          if (cnt == 2'd0 && last_burst) flag_rd <= 1'b0;
          // refresh and row end are only honoured on slot boundaries
          if (cnt == 2'(BL - 1)) begin
            col    <= row_end ? '0 : col + COL_W'(BL);
            row    <= row_end ? row + ROW_W'(1) : row;
            burst  <= burst + BURST_W'(1);
            state  <= stop ? S_PRE : S_RD;
            rd_cmd <= stop ? CMD_PRE : CMD_RD;
          end
        end
        S_PRE: if (cnt == 2'(T_RP - 1)) begin
          state  <= !flag_rd ? S_IDLE : ref_req ? S_REQ : S_ACT;
          rd_cmd <= flag_rd && !ref_req ? CMD_ACT : CMD_NOP;
        end
        default: state <= S_IDLE;
      endcase
    end
  sdram_rd_capture #(.CAS_LAT(CAS_LAT)) u_cap (
    .sclk         (sclk),
    .s_rst_n      (s_rst_n),
    .rd_slot      (state == S_RD),
    .dq           (rd_data[7:0]),
    .rfifo_wr_en  (rfifo_wr_en),
    .rfifo_wr_data(rfifo_wr_data)
  );
endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: cycle table for a single burst, plus SDRAM/scoreboard model for multi-burst, refresh and reset runs
module tb_sdram_read;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RDC = 4'b0101, PRE = 4'b0010;
  localparam int CL = 3;
  localparam int NB = 130;
`ifdef SDRAM_RD_DQ_REG_EN
  localparam int LAT = CL + 1;
`else
  localparam int LAT = CL;
`endif
  logic sclk = 0;
  always #5 sclk = ~sclk;
  logic rst1_n, trig1, en1, req1, end1, wen1;
  logic [15:0] d1;
  logic [3:0] cmd1;
  logic [12:0] addr1;
  logic [1:0] bank1;
  logic [7:0] wd1;
  logic rst2_n, trig2, en2, ref2, req2, end2, wen2;
  logic [15:0] d2;
  logic [3:0] cmd2;
  logic [12:0] addr2;
  logic [1:0] bank2;
  logic [7:0] wd2;
  sdram_read #(.CAS_LAT(CL), .RD_BURSTS(1), .COL_LAST(511)) u_one (
    .sclk(sclk), .s_rst_n(rst1_n), .rd_en(en1), .rd_req(req1), .flag_rd_end(end1),
    .ref_req(1'b0), .rd_trig(trig1), .rd_cmd(cmd1), .rd_addr(addr1), .bank_addr(bank1),
    .rd_data(d1), .rfifo_wr_en(wen1), .rfifo_wr_data(wd1));
  sdram_read #(.CAS_LAT(CL), .RD_BURSTS(NB), .COL_LAST(511)) u_dut (
    .sclk(sclk), .s_rst_n(rst2_n), .rd_en(en2), .rd_req(req2), .flag_rd_end(end2),
    .ref_req(ref2), .rd_trig(trig2), .rd_cmd(cmd2), .rd_addr(addr2), .bank_addr(bank2),
    .rd_data(d2), .rfifo_wr_en(wen2), .rfifo_wr_data(wd2));
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] hsh(input int r, input int c);
    return 8'(c * 7 + (c / 256) * 29 + r * 61);
  endfunction
  // SDRAM model: READ schedules dq words CL cycles later, keyed by absolute cycle
  int cyc = 0;
  int sc [16];
  logic [15:0] sd [16];
  initial begin
    d2 = 16'h0;
    forever begin
      @(posedge sclk);
      cyc++;
      #1;
      d2 = (sc[cyc % 16] == cyc) ? sd[cyc % 16] : (16'hDEAD ^ 16'(cyc));
    end
  end
  int wk, nrd, nend, ngrant, open_row;
  bit xrow;
  logic [16:0] h1, h2, h3;
  task automatic tick();
    @(negedge sclk);
    if (cmd2 == ACT) open_row = int'(addr2);
    if (cmd2 == PRE) chk("pre_a10", {19'd0, addr2}, 32'h400);
    if (cmd2 == RDC) begin
      for (int k = 0; k < 4; k++) begin
        sc[(cyc + CL + k) % 16] = cyc + CL + k;
        sd[(cyc + CL + k) % 16] = {8'h5A, hsh(open_row, int'(addr2[8:0]) + k)};
      end
      nrd++;
    end
    if (cmd2 != NOP) begin
      if (cmd2 == RDC && addr2 == 0 && h1 == {ACT, 13'd1} && h2 == {PRE, 13'h400} && h3 == {RDC, 13'd508}) xrow = 1;
      h3 = h2; h2 = h1; h1 = {cmd2, addr2};
    end
    if (wen2) begin
      chk($sformatf("data%0d", wk), {24'd0, wd2}, {24'd0, hsh(wk / 512, wk % 512)});
      wk++;
    end
    if (end2) nend++;
  endtask
  task automatic start_xfer();
    wk = 0; nrd = 0; nend = 0; ngrant = 0; xrow = 0;
    trig2 = 1;
    tick();
    trig2 = 0;
  endtask
  task automatic next_cmd(output logic [16:0] c);
    c = 'x;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (cmd2 != NOP) begin
        c = {cmd2, addr2};
        break;
      end
    end
  endtask
  task automatic finish_xfer(input bit rnd, input bit xtrig);
    int quiet, dly, budget;
    quiet = 0;
    dly = rnd ? $urandom_range(0, 6) : 2;
    for (budget = 0; budget < 3000 && !(wk >= 4 * NB && quiet > 12); budget++) begin
      tick();
      en2 = 0;
      if (req2) begin
        if (dly == 0) begin
          en2 = 1; ref2 = 0; ngrant++;
          dly = rnd ? $urandom_range(0, 6) : 2;
        end else dly--;
      end
      if (rnd && !ref2 && $urandom_range(0, 59) == 0) ref2 = 1;
      trig2 = xtrig && cmd2 == RDC && nrd == 20;
      quiet = (cmd2 == NOP && !wen2 && !req2) ? quiet + 1 : 0;
    end
    en2 = 0; trig2 = 0;
    chk("xfer_in_budget", {31'd0, budget < 3000}, 1);
    chk("wr_total", wk, 4 * NB);
    chk("rd_total", nrd, NB);
    chk("row_cross", {31'd0, xrow}, 1);
    chk("end_pulses", nend, ngrant);
    chk("bank", {30'd0, bank2}, 0);
  endtask
  typedef struct {
    logic trig, en;
    logic [15:0] d;
    logic [3:0] cmd;
    logic [12:0] addr;
    logic req, fend, wen;
    logic [7:0] wd;
  } vec_t;
  vec_t tv [20];
  logic [16:0] c;
  initial begin
    rst1_n = 0; rst2_n = 0;
    trig1 = 0; en1 = 0; d1 = 0; trig2 = 0; en2 = 0; ref2 = 0;
    h1 = 0; h2 = 0; h3 = 0; open_row = 0;
    for (int i = 0; i < 20; i++) begin
      tv[i].trig = 0; tv[i].en = 0; tv[i].d = 16'hA5A5; tv[i].cmd = NOP; tv[i].addr = 0;
      tv[i].req = 0; tv[i].fend = 0; tv[i].wen = 0; tv[i].wd = 0;
    end
    tv[0].trig = 1;
    for (int i = 1; i <= 3; i++) tv[i].req = 1;
    tv[3].en = 1;
    tv[4].cmd = ACT;
    tv[8].cmd = RDC;
    tv[12].cmd = PRE; tv[12].addr = 13'h400;
    tv[15].fend = 1;
    for (int k = 0; k < 4; k++) begin
      tv[8 + CL + k].d = 16'(17 * (k + 1));
      tv[8 + LAT + k].wen = 1;
      tv[8 + LAT + k].wd = 8'(17 * (k + 1));
    end
    repeat (3) tick();
    chk("rst_cmd1", {28'd0, cmd1}, {28'd0, NOP});
    chk("rst_cmd2", {28'd0, cmd2}, {28'd0, NOP});
    chk("rst_outs1", {addr1, bank1, req1, end1, wen1, wd1}, 0);
    chk("rst_outs2", {addr2, bank2, req2, end2, wen2, wd2}, 0);
    rst1_n = 1; rst2_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge sclk);
      #1;
      trig1 = tv[i].trig; en1 = tv[i].en; d1 = tv[i].d;
      @(negedge sclk);
      chk($sformatf("v%0d.cmd", i), {28'd0, cmd1}, {28'd0, tv[i].cmd});
      if (tv[i].cmd != NOP) chk($sformatf("v%0d.addr", i), {19'd0, addr1}, {19'd0, tv[i].addr});
      chk($sformatf("v%0d.req", i), {31'd0, req1}, {31'd0, tv[i].req});
      chk($sformatf("v%0d.end", i), {31'd0, end1}, {31'd0, tv[i].fend});
      chk($sformatf("v%0d.wen", i), {31'd0, wen1}, {31'd0, tv[i].wen});
      if (tv[i].wen) chk($sformatf("v%0d.wd", i), {24'd0, wd1}, {24'd0, tv[i].wd});
    end
    start_xfer();
    finish_xfer(0, 1);
    ref2 = 0;
    start_xfer();
    en2 = 1; ngrant++;
    tick();
    en2 = 0;
    for (int n = 0; n < 300 && nrd < 11; n++) tick();
    chk("ref_burst10_seen", nrd, 11);
    tick();
    ref2 = 1;
    for (int n = 0; n < 30 && !end2; n++) tick();
    chk("ref_end_pulse", {31'd0, end2}, 1);
    chk("ref_no_extra_rd", nrd, 11);
    chk("ref_pre_before_end", {15'd0, h1}, {15'd0, PRE, 13'h400});
    tick();
    chk("ref_req_hi", {31'd0, req2}, 1);
    ref2 = 0; en2 = 1; ngrant++;
    next_cmd(c);
    en2 = 0;
    chk("resume_act_row0", {15'd0, c}, {15'd0, ACT, 13'd0});
    next_cmd(c);
    chk("resume_rd_col44", {15'd0, c}, {15'd0, RDC, 13'd44});
    finish_xfer(0, 0);
    for (int t = 0; t < 3; t++) begin
      start_xfer();
      finish_xfer(1, t == 1);
    end
    ref2 = 0;
    start_xfer();
    en2 = 1;
    tick();
    en2 = 0;
    for (int n = 0; n < 40 && nrd < 1; n++) tick();
    chk("rst_first_rd", nrd, 1);
    tick();
    rst2_n = 0;
    #1;
    chk("rst_mid_cmd", {28'd0, cmd2}, {28'd0, NOP});
    chk("rst_mid_wen", {31'd0, wen2}, 0);
    for (int n = 0; n < 12; n++) begin
      tick();
      if (n == 2) rst2_n = 1;
      chk($sformatf("rst_after%0d", n), {cmd2, wen2, req2}, {NOP, 1'b0, 1'b0});
    end
    chk("rst_no_writes", wk, 0);
    start_xfer();
    finish_xfer(1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_read.md
Name: sdram_read

Overview:
- SDRAM read-path engine that issues ACTIVE / READ / PRECHARGE sequences and streams returned data into a read FIFO.
- Pairs with the existing SDRAM write engine and shares the same top-level arbiter, which handles the req/en handshake, refresh priority and the end-flag return.
- Performs BL=4 bursts on bank 0, starting at row 0 col 0, for RD_BURSTS bursts per trigger.
- Handles row crossing and pauses for refresh at burst boundaries.

Parameters:
- CAS_LAT, 3: CAS latency in sclk cycles, from the READ command to the first valid dq word (legal 2..3).
- RD_BURSTS, 256: bursts of 4 words per rd_trig; range 1..4095.
- COL_LAST, 511: last column index of a row (9-bit column address).

Ports:
- sclk  in  1  system clock
- s_rst_n  in  1  asynchronous, active-low reset
- rd_en  in  1  arbiter grant; sampled only in S_REQ
- rd_req  out  1  request to arbiter; high exactly while in S_REQ
- flag_rd_end  out  1  one-cycle pulse when the engine releases the bus
- ref_req  in  1  refresh pending; causes suspension at the next burst boundary
- rd_trig  in  1  start pulse; ignored while a transfer is active
- rd_cmd  out  4  {CS#,RAS#,CAS#,WE#}
- rd_addr  out  13  SDRAM A[12:0]
- bank_addr  out  2  fixed 2'b00
- rd_data  in  16  SDRAM dq input
- rfifo_wr_en  out  1  read-FIFO write strobe
- rfifo_wr_data  out  8  rd_data[7:0] for the matching cycle

Behaviour:
- Reset values: all outputs 0, except rd_cmd = NOP (4'b0111). Reset also sets state = S_IDLE and clears the row/col/burst counters and the valid pipeline.
- Commands:
  - NOP 0111, ACT 0011, READ 0101, PRE 0010.
  - rd_cmd is registered.
  - rd_addr is combinational from state and counters, aligned with the registered command.
- flag_rd: set on rd_trig while clear; cleared in the cycle after the final READ of burst RD_BURSTS-1.
- State machine (one-hot, 5 states):
  - S_IDLE: rd_trig -> S_REQ.
  - S_REQ: rd_req=1; on rd_en -> S_ACT.
  - S_ACT: ACT with rd_addr=row in cycle 0, then NOP. Exit to S_RD after 4 cycles (tRCD margin).
  - S_RD:
    - 4-cycle burst slots: READ at slot cycle 0, NOP at 1..3.
    - rd_addr = {4'b0, col} with col[1:0]=00; col advances by 4 per slot.
  - At the end of each slot (slot cycle 3), go to S_PRE if any of the following holds:
    - the last burst was issued;
    - ref_req=1;
    - the slot just issued col = COL_LAST-3 (row end).
    - Otherwise issue the next slot.
    - ref_req is never honoured mid-slot.
  - S_PRE:
    - PRE with A10=1 (all banks) at cycle 0, then NOP; lasts 4 cycles.
    - Exit: ref_req && flag_rd -> S_REQ; else flag_rd -> S_ACT (row+1 or same row resumes); else -> S_IDLE.
- Row crossing: when col wraps to 0, row increments; the next ACT uses the new row.
- Resume after refresh: row/col/burst counters are retained; the next ACT reopens the same row and continues at the saved col.
- flag_rd_end pulses in the S_PRE exit cycle to S_REQ or S_IDLE.
- Data capture:
  - A valid shift register tags each READ-slot cycle.
  - rfifo_wr_en goes high CAS_LAT cycles after each READ command cycle, for 4 consecutive cycles.
  - rfifo_wr_data = rd_data[7:0] in the same cycle.
  - The pipeline drains independently of state, so PRE and IDLE never truncate captured data.
- Totals: exactly 4*RD_BURSTS rfifo_wr_en pulses per trigger.
- Arithmetic: burst counter 12-bit, col 9-bit, row 13-bit. Row wraps 8191 -> 0 silently.
- Simultaneous rd_trig and an active transfer: the trigger is dropped.
- Asynchronous reset mid-burst: immediate S_IDLE; in-flight data is discarded (no FIFO writes).

Optional Feature:
- Macro SDRAM_RD_DQ_REG_EN.
- Defined: rd_data passes through an input register (IOB-friendly); rfifo_wr_en latency becomes CAS_LAT+1.
- Undefined: dq is sampled directly; latency is CAS_LAT.
- Command/state timing is identical in both builds.

Decomposition:
- Shared package sdram_pkg:
  - CMD_NOP/ACT/RD/WR/PRE/AREF/MSET codes.
  - State one-hot constants.
  - BL=4, tRCD/tRP cycle counts.
  - Column/row widths.
- Sub-module sdram_rd_capture: valid shift register (depth CAS_LAT, plus 1 with the macro) and dq byte capture, emitting rfifo_wr_en / rfifo_wr_data.

Test Plan:
- Single burst:
  - Stimulus: RD_BURSTS=1; rd_trig, rd_en granted 2 cycles later. SDRAM model returns 0x0011,0x0022,0x0033,0x0044.
  - Required response: ACT row 0; READ col 0; rfifo_wr_en pulses 4x at CAS_LAT=3 cycles after READ with data 11,22,33,44; PRE A10=1; flag_rd_end one pulse; back to IDLE.
- Row crossing:
  - Stimulus: RD_BURSTS=130, start col 0.
  - Required response: after the READ at col 508 -> PRE, ACT row 1, READ col 0; 520 FIFO writes total; no gaps in data order.
- Refresh suspension:
  - Stimulus: ref_req asserted mid-slot of burst 10.
  - Required response: slot completes; PRE; flag_rd_end pulse; rd_req high. After rd_en: ACT same row, READ col 44.
- Trigger during activity:
  - Stimulus: second rd_trig during S_RD.
  - Required response: ignored; still exactly 4*RD_BURSTS writes.
- Reset mid-operation:
  - Stimulus: s_rst_n low during CAS wait.
  - Required response: rd_cmd=0111; rfifo_wr_en=0 immediately and afterwards; state IDLE.
- Latency option:
  - Stimulus: repeat the single-burst test with SDRAM_RD_DQ_REG_EN defined.
  - Required response: FIFO writes occur at CAS_LAT+1 = 4 cycles after READ, with the same values.
